// File: rtl/fifo_rd_stream_if.sv
// Output stream of the FIFO read-side stage: valid/ready handshake with a data word.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 32
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side stage: pops the FIFO into a 2-entry skid buffer and streams it out,
// with optional burst draining. Build macro FIFO_RD_STATS_EN adds saturating counters.
module fifo_rd_stream #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 empty,
    input  logic                 almost_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_error,
    output logic                 pop,
    input  logic                 burst_mode,
    fifo_rd_stream_if.master     m_if,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     words_out,
    output logic [CNT_W-1:0]     stall_cycles
);

    typedef enum logic [1:0] {STREAM, WAIT_FILL, BURST} state_t;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        occ;
    logic [WIDTH-1:0]  head;
    logic [WIDTH-1:0]  tail;
    logic              transfer;

    assign m_if.m_valid = (occ != 2'd0);
    assign m_if.m_data  = head;
    assign transfer     = m_if.m_valid && m_if.m_ready;

    // Built only from registered state and FIFO flags; m_ready never reaches pop.
    assign pop = reset_n && !empty && (state != WAIT_FILL) && (occ != 2'd2);

    // NOTE: both skid entries are reset because m_data must read 0 straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            // NOTE: non-blocking, so the shift and the write below both see pre-edge occ/tail.
            if (transfer)
                head <= tail;
            if (pop) begin
                if (occ == 2'd0 || transfer)
                    head <= fifo_data;
                else
                    tail <= fifo_data;
            end
            occ <= occ + {1'b0, pop} - {1'b0, transfer};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= STREAM;
            hold_cnt <= '0;
        end else begin
            case (state)
                STREAM: begin
                    if (burst_mode && empty) begin
                        state    <= WAIT_FILL;
                        hold_cnt <= '0;
                    end
                end
                WAIT_FILL: begin
                    hold_cnt <= empty ? '0 : hold_cnt + 1'b1;
                    if (!burst_mode)
                        state <= STREAM;
                    else if (!empty && (!almost_empty || hold_cnt == HOLD_LAST))
                        state <= BURST;
                end
                BURST: begin
                    if (empty) begin
                        state    <= burst_mode ? WAIT_FILL : STREAM;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= STREAM;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // A new error outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_sticky <= 1'b0;
        else if (fifo_error)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_out    <= '0;
            stall_cycles <= '0;
        end else begin
            if (transfer && words_out != '1)
                words_out <= words_out + CNT_W'(1);
            if (m_if.m_valid && !m_if.m_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`else
    assign words_out    = '0;
    assign stall_cycles = '0;
`endif

    a_no_pop_on_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop && empty));

    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (m_if.m_valid && !m_if.m_ready) |=> (m_if.m_valid && $stable(m_if.m_data)));

endmodule
